// File: rtl/multdiv_seq.sv
// Sequential 32-bit signed multiply (shift-add) / divide (restoring) unit, one bit per cycle.
// Optional macro DIV_EN compiles the divider; without it a divide returns result 0 with exception.
module multdiv_seq (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state;
    logic [5:0]  count;
    logic [63:0] acc;
    logic [31:0] a_reg;     // multiplicand, or dividend shifting into quotient
    logic [31:0] b_reg;     // multiplier shifting out, or divisor
    logic        sign;
    logic        op_div;
    logic        fix_step;

    logic        start;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;

    assign start   = ((state == IDLE) || (state == DONE)) && (ctrl_MULT || ctrl_DIV);
    assign a_mag   = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
    assign b_mag   = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;
    assign mul_sum = {1'b0, acc[63:32]} + (b_reg[0] ? {1'b0, a_reg} : 33'd0);

`ifdef DIV_EN
    // Remainder stays below the divisor (at most 2^31), so 32 bits hold it between steps.
    logic [31:0] rem;
    logic [32:0] rem_sh;
    logic [33:0] trial;
    logic        q_bit;

    assign rem_sh = {rem, a_reg[31]};
    assign trial  = {1'b0, rem_sh} - {2'b00, b_reg};
    assign q_bit  = ~trial[33];
`endif

    assign data_resultRDY = (state == DONE);
    assign busy           = (state == RUN) || (state == FIX);
    assign state_dbg      = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            count          <= 6'd0;
            acc            <= 64'd0;
            a_reg          <= 32'd0;
            b_reg          <= 32'd0;
            sign           <= 1'b0;
            op_div         <= 1'b0;
            fix_step       <= 1'b0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
`ifdef DIV_EN
            rem            <= 32'd0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg    <= a_mag;
                        b_reg    <= b_mag;
                        sign     <= data_operandA[31] ^ data_operandB[31];
                        op_div   <= !ctrl_MULT;
                        count    <= 6'd0;
                        acc      <= 64'd0;
                        fix_step <= 1'b0;
`ifdef DIV_EN
                        rem      <= 32'd0;
                        state    <= RUN;
`else
                        state    <= ctrl_MULT ? RUN : FIX;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (!op_div) begin
                        acc   <= {mul_sum, acc[31:1]};
                        b_reg <= b_reg >> 1;
                    end
`ifdef DIV_EN
                    else begin
                        rem   <= q_bit ? trial[31:0] : rem_sh[31:0];
                        a_reg <= {a_reg[30:0], q_bit};
                    end
`endif
                    count <= count + 6'd1;
                    if (count == 6'd31) state <= FIX;
                end
                FIX: begin
                    // First FIX cycle applies the sign, second one resolves result and exception.
                    if (!fix_step) begin
                        fix_step <= 1'b1;
                        if (sign) begin
                            if (op_div) a_reg <= ~a_reg + 32'd1;
                            else        acc   <= ~acc + 64'd1;
                        end
                    end else begin
                        state <= DONE;
                        if (!op_div) begin
                            data_result    <= acc[31:0];
                            data_exception <= (acc[63:32] != {32{acc[31]}});
                        end else begin
`ifdef DIV_EN
                            if (b_reg == 32'd0) begin
                                data_result    <= 32'd0;
                                data_exception <= 1'b1;
                            end else begin
                                // A positive 2^31 quotient only arises from 0x80000000 / -1.
                                data_result    <= a_reg;
                                data_exception <= (a_reg == 32'h8000_0000) && !sign;
                            end
`else
                            data_result    <= 32'd0;
                            data_exception <= 1'b1;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed self-checking bench for multdiv_seq; divide cases follow the DIV_EN build option.
module tb_multdiv_seq;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = 32'd0;
    logic [31:0] data_operandB = 32'd0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;
    logic [1:0]  state_dbg;

    int n_vec = 0;
    int n_err = 0;
    logic [32:0] exp_q[$];

    multdiv_seq dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy),
        .state_dbg      (state_dbg)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one start pulse around a single rising edge, then scramble the operands.
    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT = m;
        ctrl_DIV = d;
        data_operandA = a;
        data_operandB = b;
        exp_q.push_back(33'd0);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_rdy(output int n);
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!data_resultRDY && n < 60);
    endtask

    task automatic check_result(input string tag, input logic [31:0] res, input logic exc);
        logic [32:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'd0;
        e = {exc, res};
        check({tag, "_res"}, data_result, e[31:0]);
        check({tag, "_exc"}, {31'd0, data_exception}, {31'd0, e[32]});
        check({tag, "_busy_at_rdy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_op(input string tag, input logic m, input logic d,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic exc, input int lat);
        int n;
        start_op(m, d, a, b);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_rdy(n);
        check({tag, "_lat"}, n, lat);
        check_result(tag, res, exc);
        @(posedge clock);
        #1;
        check({tag, "_rdy_width"}, {31'd0, data_resultRDY}, 32'd0);
    endtask

    initial begin
        int n;
        int strobes;
        // reset state
        repeat (2) @(negedge clock);
        check("rst_result", data_result, 32'd0);
        check("rst_exc", {31'd0, data_exception}, 32'd0);
        check("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;

        // multiply: sign, overflow, most-negative operand, simultaneous starts
        do_op("mul_7x-6", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, 34);
        do_op("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 34);
        do_op("mul_minneg", 1'b1, 1'b0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, 34);
        do_op("both_ctrl", 1'b1, 1'b1, 32'd6, 32'd3, 32'd18, 1'b0, 34);

`ifdef DIV_EN
        do_op("div_-7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 34);
        do_op("div_100/7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 1'b0, 34);
        do_op("div_by0", 1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1, 34);
        do_op("div_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 34);
`else
        do_op("div_off", 1'b0, 1'b1, 32'd5, 32'd3, 32'd0, 1'b1, 2);
`endif

        // starts while busy are ignored
        start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA);
        fork
            begin
                repeat (4) @(negedge clock);
                ctrl_MULT = 1'b1;
                data_operandA = 32'd3;
                data_operandB = 32'd3;
                @(negedge clock);
                ctrl_MULT = 1'b0;
                repeat (14) @(negedge clock);
                ctrl_MULT = 1'b1;
                @(negedge clock);
                ctrl_MULT = 1'b0;
            end
            wait_rdy(n);
        join
        check("busy_ign_lat", n, 34);
        check_result("busy_ign", 32'hFFFF_FFD6, 1'b0);

        // back-to-back: start issued in the DONE cycle
        exp_q.push_back(33'd0);
        ctrl_MULT = 1'b1;
        data_operandA = 32'hFFFF_FFFD;
        data_operandB = 32'hFFFF_FFFB;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        check("b2b_accept_busy", {31'd0, busy}, 32'd1);
        check("b2b_accept_rdy", {31'd0, data_resultRDY}, 32'd0);
        wait_rdy(n);
        check("b2b_spacing", n + 1, 35);
        check_result("b2b", 32'd15, 1'b0);

        // result holds after the strobe
        repeat (5) @(posedge clock);
        #1;
        check("hold_res", data_result, 32'd15);

        // reset mid-run discards the operation
        start_op(1'b1, 1'b0, 32'd9, 32'd9);
        void'(exp_q.pop_back());
        repeat (10) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_result", data_result, 32'd0);
        check("arst_exc", {31'd0, data_exception}, 32'd0);
        check("arst_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_state", {30'd0, state_dbg}, 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) strobes++;
        end
        check("arst_no_strobe", strobes, 0);

        do_op("post_rst", 1'b1, 1'b0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, 34);
        do_op("post_rst2", 1'b1, 1'b0, 32'd100, 32'hFFFF_FF9C, 32'hFFFF_D8F0, 1'b0, 34);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multdiv_seq.md
# multdiv_seq

Sequential 32-bit signed multiply/divide unit for the processor execute stage. It consumes the same 32-bit operand buses as the barrel shift unit and iterates one single-bit shift per cycle: shift-add for multiplication, restoring shift-subtract for division. It raises a one-cycle ready strobe so the pipeline stall logic can release the destination writeback.

## Interface
- No parameters. Width fixed at 32.
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- ctrl_MULT  in  1  start-multiply pulse, sampled on rising edge
- ctrl_DIV  in  1  start-divide pulse, sampled on rising edge
- data_operandA  in  32  multiplicand / dividend, two's complement
- data_operandB  in  32  multiplier / divisor, two's complement
- data_result  out  32  product low word or quotient
- data_exception  out  1  overflow / divide-by-zero flag, valid with data_resultRDY
- data_resultRDY  out  1  one-cycle completion strobe
- busy  out  1  high while an operation is in flight

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE/DONE + ctrl_MULT or ctrl_DIV high:
  - latch |A|, |B|, sign = A[31]^B[31], and op;
  - clear the 6-bit count and the 64-bit accumulator;
  - go to RUN.
- Both ctrl lines high in the same cycle: MULT wins.
- RUN, multiply: per cycle, if multiplier LSB=1 then add the multiplicand to the upper half of the accumulator; then shift the accumulator right 1 and shift the multiplier right 1.
- RUN, divide: per cycle, shift the {remainder, dividend} pair left 1. Trial-subtract |B| from the remainder. If non-negative, keep the difference and set quotient bit = 1; otherwise restore and set the bit to 0.
- RUN lasts exactly 32 cycles (count 0..31), then goes to FIX.
- FIX, multiply:
  - negate the 64-bit product if sign=1;
  - result = product[31:0];
  - exception = 1 if product[63:32] is not all copies of product[31].
- FIX, divide:
  - negate the quotient if sign=1 (truncation toward zero);
  - divisor 0 gives result 0, exception 1;
  - A=0x80000000 with B=0xFFFFFFFF gives result 0x80000000, exception 1.
- DONE: data_resultRDY=1 for this single cycle, then go to IDLE unless a new start is accepted.
- ctrl_* while busy=1 (RUN, FIX) is ignored; no queueing.
- data_result and data_exception hold their last values until the next FIX.
- Magnitude of 0x80000000 is 0x80000000 treated as unsigned; the datapath is unsigned 33-bit internally.

## Timing
- Reset (async assert, any state): state=IDLE, data_result=0, data_exception=0, data_resultRDY=0, busy=0, count=0. The operation in flight is discarded with no strobe. Deassertion is synchronised externally.
- Start accepted at edge E0. busy=1 from after E0 until the edge that enters DONE.
- data_resultRDY is high in the cycle after edge E0+34: 32 RUN cycles + FIX + DONE entry.
- Back-to-back: a start in the DONE cycle is accepted. Strobes are then 35 cycles apart.
- Operands are sampled only at the accept edge; later changes have no effect.

## Configuration
- DIV_EN defined: full restoring divider as described above.
- DIV_EN undefined:
  - divide datapath and remainder register are not compiled;
  - ctrl_DIV alone is accepted and goes IDLE→FIX→DONE;
  - data_resultRDY is asserted 2 cycles after acceptance, with result 0 and exception 1;
  - multiply behaviour is unchanged.

## Test plan
- A=7, B=-6 (0xFFFFFFFA), ctrl_MULT pulse:
  - result 0xFFFFFFD6, exception 0;
  - data_resultRDY asserted for exactly 1 cycle, 34 edges after the pulse.
- A=0x00010000, B=0x00010000, MULT: result 0x00000000, exception 1. A=0x80000000, B=1, MULT: result 0x80000000, exception 0.
- DIV_EN defined, divide cases:
  - A=-7, B=2: result 0xFFFFFFFD;
  - A=100, B=7: result 14;
  - A=5, B=0: result 0, exception 1;
  - all with 34-cycle latency.
- Busy and restart:
  - ctrl_MULT pulsed again at cycles 5 and 20 of a run: ignored, the first result is unaffected;
  - a new start in the DONE cycle produces a second strobe 35 cycles later.
- Reset and simultaneous starts:
  - reset_n low at RUN cycle 10: all outputs 0 immediately, no strobe;
  - the next operation after release is correct.
  - ctrl_MULT and ctrl_DIV both high with A=6, B=3: result 18 (MULT wins).
- DIV_EN undefined: ctrl_DIV gives strobe after 2 cycles with result 0, exception 1; MULT regression still passes.
